pr_node_responder: RTL and testbench
====================================

// Module: pr_node_responder
// PURPOSE
//  Responder end of the node-value query channel issued by the PageRank walker
//  (request = 6-bit node id, reply = {id, value}). Holds a snapshot of all N
//  node rank/weight values and answers queued lookups in order with valid/ready
//  handshakes. Sits between the pageRank core output bus and any requesting agent.
// PARAMETERS
//  N      64  number of nodes; legal ids are 0..N-1 (N <= 64)
//  WIDTH  16  bits per node value (unsigned fixed point, 16'hFFFF ~ 1.0)
//  DEPTH  2   pending-response FIFO entries (>= 1)
// PORTS
//  clk         in   1              rising-edge clock
//  reset       in   1              synchronous, active-high
//  node_vals   in   N*WIDTH        node i value at [i*WIDTH +: WIDTH]
//  load        in   1              snapshot node_vals into the table this cycle
//  req_valid   in   1              request present
//  req_ready   out  1              responder can accept a request
//  req_id      in   6              requested node id
//  rsp_valid   out  1              response at FIFO head
//  rsp_ready   in   1              consumer takes response
//  rsp_data    out  WIDTH+6        {id[5:0], value[WIDTH-1:0]}
//  rsp_err     out  1              head response was for id >= N
//  pending     out  $clog2(DEPTH+1) FIFO occupancy
//  served_cnt  out  16             completed responses, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Reset: table all 0, FIFO empty, req_ready=0 in reset cycle, rsp_valid=0,
//    rsp_data=0, rsp_err=0, pending=0, served_cnt=0. Reset aborts any
//    in-flight request/response; no partial state survives.
//  - Table load: load=1 copies node_vals into table at the clock edge. During a
//    load cycle req_ready=0 (no accept); every later accept sees the new values.
//  - req_ready = !reset && !load && (pending < DEPTH). Full FIFO blocks accept
//    even when a pop happens in the same cycle (no pass-through).
//  - Accept (req_valid && req_ready): push {req_id, table[req_id], err} where
//    err = (req_id >= N); for err the value field is 0. Value is captured at
//    accept time; a later load does not alter queued entries.
//  - Latency: accepted at edge t -> rsp_valid=1 with that data after edge t,
//    i.e. visible in cycle t+1. Back-to-back accepts give one response/cycle
//    when rsp_ready=1 steadily.
//  - Output: rsp_valid = (pending != 0); rsp_data/rsp_err show FIFO head,
//    held stable while rsp_valid && !rsp_ready. When rsp_valid=0, rsp_data and
//    rsp_err are 0.
//  - Pop on rsp_valid && rsp_ready; served_cnt increments by 1 per pop
//    (including err responses), mod 2^16.
//  - Simultaneous push and pop (not full): occupancy unchanged, order kept.
//  - FIFO pointers wrap modulo DEPTH; strict FIFO ordering of responses.
//  - req_id, req_valid ignored when req_ready=0; rsp_ready ignored when empty.
// TESTING
//  1 load with node0..3 = 5555,8000,FFFF,8000; req id 2 -> next cycle
//    rsp_valid=1, rsp_data={6'd2,16'hFFFF}, rsp_err=0; pop -> served_cnt=1.
//  2 rsp_ready=0, issue ids 0,1,3 back-to-back (DEPTH=2) -> ids 0,1 accepted,
//    req_ready=0, pending=2; raise rsp_ready -> 5555, 8000, then id 3 -> 8000.
//  3 N=16: req id 20 -> rsp_data={6'd20,16'h0000}, rsp_err=1; served_cnt+1.
//  4 load=1 with req_valid=1 same cycle -> req_ready=0, no accept; next
//    cycle request returns the newly loaded value; queued old entry unchanged.
//  5 reset asserted with pending=2 -> next cycle pending=0, rsp_valid=0,
//    served_cnt=0, table reads 0 after release.
//  6 65536 pops with continuous req/rsp -> served_cnt wraps to 0, one
//    response per cycle, no bubbles after first.

Source files
------------

// File: rtl/pr_node_responder.sv
// pr_node_responder: answers in-order node-value lookups from a snapshot table.
// Each accepted request {id} is queued as {id, value, err} in a small FIFO and
// presented on the rsp_* handshake. The value is captured when the request is
// accepted.
module pr_node_responder #(
  parameter int unsigned N     = 64,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N*WIDTH-1:0]           node_vals,
  input  logic                         load,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [5:0]                   req_id,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIDTH+5:0]             rsp_data,
  output logic                         rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic [15:0]                  served_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] tbl    [N];
  logic [5:0]       f_id   [DEPTH];
  logic [WIDTH-1:0] f_val  [DEPTH];
  logic             f_err  [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             id_err;
  logic [WIDTH-1:0] id_val;
  logic             push;
  logic             pop;

  // Advance a FIFO pointer, wrapping modulo DEPTH.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Out-of-range detection; with a full 64-entry table every 6-bit id is legal.
  generate
    if (N >= 64) begin : g_no_err
      always_comb id_err = 1'b0;
    end else begin : g_err
      always_comb id_err = (req_id >= 6'(N));
    end
  endgenerate

  // Table lookup for the incoming request; errored ids carry a zero value.
  always_comb begin
    id_val = '0;
    if (!id_err) id_val = tbl[req_id[IW-1:0]];
  end

  // Handshake qualification. A full FIFO blocks accept even while popping.
  always_comb begin
    req_ready = !reset && !load && (count < CW'(DEPTH));
    rsp_valid = (count != '0);
    push      = req_valid && req_ready;
    pop       = rsp_valid && rsp_ready;
  end

  // Head presentation; outputs are forced to zero while the FIFO is empty.
  always_comb begin
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (rsp_valid) begin
      rsp_data = {f_id[rd_ptr], f_val[rd_ptr]};
      rsp_err  = f_err[rd_ptr];
    end
    pending = count;
  end

  // Snapshot table: cleared by reset, overwritten wholesale on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) tbl[i] <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < N; i++) tbl[i] <= node_vals[i*WIDTH +: WIDTH];
    end
  end

  // Response FIFO storage and pointers; occupancy holds on simultaneous push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        f_id[i]  <= '0;
        f_val[i] <= '0;
        f_err[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        f_id[wr_ptr]  <= req_id;
        f_val[wr_ptr] <= id_val;
        f_err[wr_ptr] <= id_err;
        wr_ptr        <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Completed-response counter, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset)    served_cnt <= '0;
    else if (pop) served_cnt <= served_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pr_node_responder.sv
// Scoreboard bench for pr_node_responder (N=16 so out-of-range ids are reachable).
`timescale 1ns/1ps
module tb_pr_node_responder;

  localparam int unsigned NN = 16;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NN*W-1:0]   node_vals;
  logic              load;
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_id;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W+5:0]      rsp_data;
  logic              rsp_err;
  logic [1:0]        pending;
  logic [15:0]       served_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0]  mdl [NN];
  logic [W-1:0]  nv  [NN];
  logic [W+6:0]  exp_q [$];

  pr_node_responder #(.N(NN), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .node_vals(node_vals), .load(load),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .pending(pending), .served_cnt(served_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id);
    logic         e;
    logic [W-1:0] v;
    e = (id >= int'(NN));
    v = e ? '0 : mdl[id];
    exp_q.push_back({e, 6'(id), v});
  endtask

  task automatic issue(input int id, input bit exp_acc);
    req_valid = 1'b1;
    req_id    = 6'(id);
    @(negedge clk);
    chk("req_ready", req_ready, exp_acc);
    if (exp_acc) push_exp(id);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_load(input bit with_req, input int id);
    for (int i = 0; i < int'(NN); i++) node_vals[i*W +: W] = nv[i];
    load      = 1'b1;
    req_valid = with_req;
    req_id    = 6'(id);
    @(negedge clk);
    chk("load_blocks_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    load      = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < int'(NN); i++) mdl[i] = nv[i];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every pop is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {9'b0, rsp_err, rsp_data}, 32'hDEAD);
      end else begin
        logic [W+6:0] e;
        e = exp_q.pop_front();
        chk("rsp", {9'b0, rsp_err, rsp_data}, {9'b0, e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; load = 1'b0; req_valid = 1'b0; req_id = '0; rsp_ready = 1'b0;
    node_vals = '0;
    for (int i = 0; i < int'(NN); i++) begin mdl[i] = '0; nv[i] = '0; end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_pending", pending, 0);
    chk("rst_served", served_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    // 1: load and single lookup
    nv[0] = 16'h5555; nv[1] = 16'h8000; nv[2] = 16'hFFFF; nv[3] = 16'h8000;
    for (int i = 4; i < int'(NN); i++) nv[i] = 16'(i * 16'h0111);
    do_load(1'b0, 0);
    rsp_ready = 1'b1;
    issue(2, 1'b1);
    @(negedge clk);
    chk("t1_latency", rsp_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_served", served_cnt, 1);
    chk("t1_empty_valid", rsp_valid, 1'b0);
    chk("t1_empty_data", rsp_data, 0);
    chk("t1_empty_err", rsp_err, 1'b0);
    chk("t1_pending", pending, 0);
    @(posedge clk); #1;

    // 2: fill FIFO, full blocks accept even while popping
    rsp_ready = 1'b0;
    issue(0, 1'b1);
    issue(1, 1'b1);
    req_valid = 1'b1; req_id = 6'd3;
    @(negedge clk);
    chk("t2_full_ready", req_ready, 1'b0);
    chk("t2_pending", pending, 2);
    chk("t2_head_hold", rsp_data, {6'd0, 16'h5555});
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2_no_passthru", req_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_ready_again", req_ready, 1'b1);
    push_exp(3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    idle(2);
    @(negedge clk);
    chk("t2_pending0", pending, 0);
    chk("t2_served", served_cnt, 4);
    @(posedge clk); #1;

    // 3: out-of-range ids and the N-1 / N boundary
    issue(20, 1'b1);
    issue(16, 1'b1);
    issue(15, 1'b1);
    idle(2);
    @(negedge clk);
    chk("t3_served", served_cnt, 7);
    @(posedge clk); #1;

    // 4: load blocks accept; queued entry keeps its old value
    rsp_ready = 1'b0;
    issue(1, 1'b1);
    nv[1] = 16'h1234;
    do_load(1'b1, 1);
    @(negedge clk);
    chk("t4_no_accept", pending, 1);
    @(posedge clk); #1;
    issue(1, 1'b1);
    rsp_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("t4_served", served_cnt, 9);
    chk("t4_pending0", pending, 0);
    @(posedge clk); #1;

    // 5: reset with a full FIFO
    rsp_ready = 1'b0;
    issue(2, 1'b1);
    issue(3, 1'b1);
    @(negedge clk);
    chk("t5_pending2", pending, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < int'(NN); i++) mdl[i] = '0;
    @(negedge clk);
    chk("t5_rst_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_pending", pending, 0);
    chk("t5_valid", rsp_valid, 1'b0);
    chk("t5_served", served_cnt, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(2, 1'b1);

    // 6: streaming until served_cnt wraps (65536 pops since reset)
    for (int i = 0; i < int'(NN); i++) nv[i] = 16'(16'h1000 + i);
    do_load(1'b0, 0);
    for (int k = 0; k < 65535; k++) begin
      req_valid = 1'b1;
      req_id    = 6'(k % 20);
      @(negedge clk);
      chk("stream_ready", req_ready, 1'b1);
      if (k > 0) chk("no_bubble", rsp_valid, 1'b1);
      push_exp(k % 20);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    idle(2);
    @(negedge clk);
    chk("t6_wrap", served_cnt, 0);
    chk("t6_pending", pending, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
